obj_line_renderer: RTL and testbench
====================================

OBJ_LINE_RENDERER -- requirements
Module: obj_line_renderer

Interface
REQ-001 Parameter NUM_OBJ, default 128: object descriptors scanned per line, indices 0..NUM_OBJ-1.
REQ-002 Parameter LINE_W, default 240: visible columns per line.
REQ-003 Parameter CYCLE_BUDGET, default 1210: maximum clock cycles from line_start to forced DONE.
REQ-004 Parameter IDX_W, default $clog2(NUM_OBJ): object index width.
REQ-005 clock  in  1  sole clock; all state updates on posedge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 line_start  in  1  single-cycle pulse: swap buffers, begin rendering line.
REQ-008 line  in  8  scanline to render, sampled when line_start=1.
REQ-009 obj_idx  out  IDX_W  descriptor index requested.
REQ-010 obj_desc  in  34  {en[33], y[32:25], x[24:16], wcode[15:14], hcode[13:12], pri[11:10], tile[9:0]}, valid exactly 1 cycle after obj_idx.
REQ-011 pix_addr  out  22  {tile, row_in_obj[5:0], col_in_obj[5:0]}.
REQ-012 pix_data  in  8  colour index, valid 1 cycle after pix_addr; 0 = transparent.
REQ-013 rd_col  in  8  front-buffer read column.
REQ-014 rd_data  out  10  {pri[9:8], colour[7:0]} of front buffer at rd_col, registered, 1-cycle latency; rd_col >= LINE_W returns 10'h300.
REQ-015 busy  out  1  high from the cycle after line_start until DONE.
REQ-016 overflow  out  1  budget exhausted before all NUM_OBJ objects processed; holds until next line_start.
REQ-017 obj_count  out  IDX_W+1  visible objects fully drawn this line.

Function
REQ-018 Two LINE_W x 10-bit line buffers; front buffer read-only via rd_col, back buffer written by renderer; line_start swaps roles in the same cycle.
REQ-019 Size decode for wcode/hcode: 0->8, 1->16, 2->32, 3->64 pixels.
REQ-020 States: IDLE, CLEAR, FETCH, WAIT, DRAW, DONE.
REQ-021 line_start in any state: next state CLEAR, budget counter 0, obj index 0, obj_count 0, overflow 0; in-flight pixel writes discarded.
REQ-022 CLEAR: writes 10'h300 to back-buffer columns 0..LINE_W-1, one per cycle, then FETCH.
REQ-023 FETCH: drives obj_idx, next WAIT.
REQ-024 WAIT: object visible iff en=1 and (line - y) mod 256 < height; visible -> DRAW with col_in_obj=0; else index+1, FETCH, or DONE if index = NUM_OBJ-1.
REQ-025 DRAW: one pix_addr per cycle, col_in_obj 0..width-1, row_in_obj = (line - y) mod 256; after last column, obj_count+1 and advance index as in REQ-024.
REQ-026 Write, 1 cycle after pix_addr: column c = x + col_in_obj (10-bit sum); written iff pix_data != 0, c < LINE_W, and (stored colour = 0 or pri < stored pri); equal pri keeps lower-index object.
REQ-027 Budget counter increments every non-IDLE, non-DONE cycle; reaching CYCLE_BUDGET forces DONE, sets overflow=1 if objects remained, drops the write pending at that cycle.
REQ-028 DONE: busy=0, holds until line_start; back buffer untouched.
REQ-029 Simultaneous line_start and budget expiry: line_start wins, overflow=0.

Reset
REQ-030 Reset: state IDLE, busy 0, overflow 0, obj_count 0, obj_idx 0, pix_addr 0, rd_data 10'h300, buffer select 0, budget counter 0; buffer contents undefined until first CLEAR completes.
REQ-031 Reset asserted mid-render overrides line_start and aborts with no further buffer writes.

Verification
REQ-032 One object en=1,y=10,x=20,8x8,pri=2,pix_data=5; line_start line=12, then line_start again -> front cols 20..27 = 10'h205, others 10'h300, obj_count=1.
REQ-033 Obj0 pri=1 colour 3 and obj1 pri=1 colour 7 at same x -> colour 3; obj1 pri=0 -> colour 7; obj1 pixel_data 0 -> colour 3 kept.
REQ-034 x=236, width 16 -> only cols 236..239 written; x=300 -> no writes, obj_count=1.
REQ-035 y=250, height 16, line=3 -> visible, row_in_obj=9; line=10 -> not visible.
REQ-036 128 visible 64-wide objects -> overflow=1 at cycle 1210, busy falls, obj_count < 128.
REQ-037 line_start during DRAW -> CLEAR restarts, buffers swapped, overflow 0; reset pulse mid-DRAW -> busy 0, rd_data 10'h300.

Source files
------------

// File: rtl/obj_line_renderer.sv
// Per-scanline sprite renderer: scans object descriptors, draws visible rows into a
// back line buffer with priority/transparency, and serves the front buffer for readout.
module obj_line_renderer #(
  parameter int NUM_OBJ      = 128,
  parameter int LINE_W       = 240,
  parameter int CYCLE_BUDGET = 1210,
  parameter int IDX_W        = $clog2(NUM_OBJ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             line_start,
  input  logic [7:0]       line,
  output logic [IDX_W-1:0] obj_idx,
  input  logic [33:0]      obj_desc,
  output logic [21:0]      pix_addr,
  input  logic [7:0]       pix_data,
  input  logic [7:0]       rd_col,
  output logic [9:0]       rd_data,
  output logic             busy,
  output logic             overflow,
  output logic [IDX_W:0]   obj_count
);

  localparam int COL_W = $clog2(LINE_W);
  localparam int BUD_W = $clog2(CYCLE_BUDGET + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, DRAW, DONE} state_t;

  state_t           state;
  logic             buf_sel;
  logic             back_sel;
  logic [9:0]       line_buf [2][LINE_W];
  logic [7:0]       line_r;
  logic [COL_W-1:0] clear_col;
  logic [BUD_W-1:0] budget;
  logic [5:0]       col, col_last, cur_row;
  logic [8:0]       cur_x;
  logic [1:0]       cur_pri;
  logic [9:0]       cur_tile;
  logic             wr_pend;
  logic [9:0]       wr_col;
  logic [1:0]       wr_pri;

  function automatic logic [6:0] size_px(input logic [1:0] code);
    return 7'd8 << code;
  endfunction

  logic       d_en, d_visible;
  logic [7:0] d_y, d_dy;
  logic [8:0] d_x;
  logic [1:0] d_wcode, d_hcode, d_pri;
  logic [9:0] d_tile;

  assign {d_en, d_y, d_x, d_wcode, d_hcode, d_pri, d_tile} = obj_desc;
  assign d_dy      = line_r - d_y;
  assign d_visible = d_en && (d_dy < {1'b0, size_px(d_hcode)});
  assign back_sel  = ~buf_sel;

  logic active, budget_hit, last_obj, natural_done;
  logic [9:0] stored;
  logic clr_we, pix_we;

  assign active       = (state != IDLE) && (state != DONE);
  assign budget_hit   = active && (budget == BUD_W'(CYCLE_BUDGET - 1));
  assign last_obj     = (obj_idx == IDX_W'(NUM_OBJ - 1));
  assign natural_done = last_obj && (((state == WAIT) && !d_visible) ||
                                     ((state == DRAW) && (col == col_last)));

  // A pixel lands only over an empty cell or one held by strictly lower priority,
  // so on a priority tie the earlier (lower-index) object stays.
  assign stored = line_buf[back_sel][wr_col[COL_W-1:0]];
  assign pix_we = wr_pend && !reset && !line_start && !budget_hit &&
                  (pix_data != 8'd0) && (wr_col < 10'(LINE_W)) &&
                  ((stored[7:0] == 8'd0) || (wr_pri < stored[9:8]));
  assign clr_we = (state == CLEAR) && !reset && !line_start;

  // NOTE: the line buffers carry no reset; CLEAR initialises them before any use.
  always_ff @(posedge clock) begin
    if (clr_we)
      line_buf[back_sel][clear_col] <= 10'h300;
    else if (pix_we)
      line_buf[back_sel][wr_col[COL_W-1:0]] <= {wr_pri, pix_data};
  end

  always_ff @(posedge clock) begin
    if (reset)
      rd_data <= 10'h300;
    else if ({1'b0, rd_col} < 9'(LINE_W))
      rd_data <= line_buf[buf_sel][rd_col[COL_W-1:0]];
    else
      rd_data <= 10'h300;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      obj_count <= '0;
      obj_idx   <= '0;
      pix_addr  <= '0;
      buf_sel   <= 1'b0;
      budget    <= '0;
      wr_pend   <= 1'b0;
      wr_col    <= '0;
      wr_pri    <= '0;
      clear_col <= '0;
      line_r    <= '0;
      col       <= '0;
      col_last  <= '0;
      cur_row   <= '0;
      cur_x     <= '0;
      cur_pri   <= '0;
      cur_tile  <= '0;
    end else if (line_start) begin
      buf_sel   <= ~buf_sel;
      state     <= CLEAR;
      busy      <= 1'b1;
      overflow  <= 1'b0;
      obj_count <= '0;
      obj_idx   <= '0;
      budget    <= '0;
      wr_pend   <= 1'b0;
      clear_col <= '0;
      line_r    <= line;
    end else begin
      wr_pend <= 1'b0;
      if (active) budget <= budget + BUD_W'(1);
      case (state)
        CLEAR: begin
          clear_col <= clear_col + COL_W'(1);
          if (clear_col == COL_W'(LINE_W - 1)) state <= FETCH;
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (d_visible) begin
            cur_x    <= d_x;
            cur_pri  <= d_pri;
            cur_tile <= d_tile;
            cur_row  <= d_dy[5:0];
            col_last <= 6'(size_px(d_wcode) - 7'd1);
            col      <= '0;
            pix_addr <= {d_tile, d_dy[5:0], 6'd0};
            state    <= DRAW;
          end else if (last_obj) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            obj_idx <= obj_idx + IDX_W'(1);
            state   <= FETCH;
          end
        end
        DRAW: begin
          wr_pend <= 1'b1;
          wr_col  <= 10'(cur_x) + 10'(col);
          wr_pri  <= cur_pri;
          if (col == col_last) begin
            obj_count <= obj_count + (IDX_W+1)'(1);
            if (last_obj) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              obj_idx <= obj_idx + IDX_W'(1);
              state   <= FETCH;
            end
          end else begin
            col      <= col + 6'd1;
            pix_addr <= {cur_tile, cur_row, col + 6'd1};
          end
        end
        default: ;
      endcase
      // Budget expiry overrides whatever the scan would have done this cycle.
      if (budget_hit) begin
        state    <= DONE;
        busy     <= 1'b0;
        wr_pend  <= 1'b0;
        overflow <= !natural_done;
      end
    end
  end

endmodule

// File: tb/tb_obj_line_renderer.sv
// Directed bench for obj_line_renderer: behavioural descriptor/pixel memories,
// render-then-swap sequences, front-buffer readback against hand-computed values.
module tb_obj_line_renderer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  line = '0;
  logic [6:0]  obj_idx;
  logic [33:0] obj_desc = '0;
  logic [21:0] pix_addr;
  logic [7:0]  pix_data = '0;
  logic [7:0]  rd_col = '0;
  logic [9:0]  rd_data;
  logic        busy, overflow;
  logic [7:0]  obj_count;

  int checks = 0;
  int errors = 0;

  logic [33:0] objs [128];
  logic [7:0]  tile_col [16];

  obj_line_renderer dut (
    .clock(clock), .reset(reset), .line_start(line_start), .line(line),
    .obj_idx(obj_idx), .obj_desc(obj_desc), .pix_addr(pix_addr), .pix_data(pix_data),
    .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .overflow(overflow),
    .obj_count(obj_count)
  );

  always #5 clock = ~clock;

  // Tiles with bit 9 set return row+1 so the row the DUT requests is observable.
  function automatic logic [7:0] pix_of(input logic [21:0] a);
    logic [9:0] tile;
    tile = a[21:12];
    if (tile[9]) return 8'({2'b00, a[11:6]} + 8'd1);
    return tile_col[tile[3:0]];
  endfunction

  always @(posedge clock) begin
    obj_desc <= objs[obj_idx];
    pix_data <= pix_of(pix_addr);
  end

  function automatic logic [33:0] mk(input int en, input int y, input int x, input int w,
                                     input int h, input int pri, input int tile);
    return {1'(en), 8'(y), 9'(x), 2'(w), 2'(h), 2'(pri), 10'(tile)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] l);
    line = l;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic render(input logic [7:0] l, input string tag, output int n);
    pulse(l);
    wait_done(tag, n);
  endtask

  task automatic check_col(input string tag, input int col, input logic [9:0] exp);
    rd_col = 8'(col);
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic clear_objs();
    for (int i = 0; i < 128; i++) objs[i] = '0;
  endtask

  initial begin
    int n;
    clear_objs();
    for (int i = 0; i < 16; i++) tile_col[i] = 8'd0;
    tile_col[1] = 8'd5;
    tile_col[2] = 8'd3;
    tile_col[3] = 8'd7;
    tile_col[4] = 8'd0;

    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_obj_count", 32'(obj_count), 32'd0);
    check("rst_obj_idx", 32'(obj_idx), 32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h300);

    // Single 8x8 object, pri 2, colour 5, drawn on row 2.
    objs[0] = mk(1, 10, 20, 0, 0, 2, 1);
    render(8'd12, "single", n);
    check("single_cycles", 32'(n), 32'd504);
    check("single_count", 32'(obj_count), 32'd1);
    check("single_overflow", 32'(overflow), 32'd0);
    pulse(8'd0);
    check_col("single_c19", 19, 10'h300);
    check_col("single_c20", 20, 10'h205);
    check_col("single_c27", 27, 10'h205);
    check_col("single_c28", 28, 10'h300);
    wait_done("single_show", n);

    // Priority and transparency between two overlapping objects.
    clear_objs();
    objs[0] = mk(1, 0, 50, 0, 0, 1, 2);
    objs[1] = mk(1, 0, 50, 0, 0, 1, 3);
    render(8'd0, "tie", n);
    check("tie_count", 32'(obj_count), 32'd2);
    pulse(8'd0);
    check_col("tie_c50", 50, 10'h103);
    wait_done("tie_show", n);
    objs[1] = mk(1, 0, 50, 0, 0, 0, 3);
    render(8'd0, "hipri", n);
    pulse(8'd0);
    check_col("hipri_c50", 50, 10'h007);
    wait_done("hipri_show", n);
    objs[1] = mk(1, 0, 50, 0, 0, 0, 4);
    render(8'd0, "transp", n);
    check("transp_count", 32'(obj_count), 32'd2);
    pulse(8'd0);
    check_col("transp_c50", 50, 10'h103);
    wait_done("transp_show", n);

    // Right-edge clipping and fully off-screen x.
    clear_objs();
    objs[0] = mk(1, 0, 236, 1, 0, 0, 2);
    render(8'd0, "clip", n);
    pulse(8'd0);
    check_col("clip_c235", 235, 10'h300);
    check_col("clip_c236", 236, 10'h003);
    check_col("clip_c239", 239, 10'h003);
    check_col("clip_c240", 240, 10'h300);
    check_col("clip_c255", 255, 10'h300);
    wait_done("clip_show", n);
    objs[0] = mk(1, 0, 300, 0, 0, 0, 2);
    render(8'd0, "offx", n);
    check("offx_count", 32'(obj_count), 32'd1);
    pulse(8'd0);
    check_col("offx_c44", 44, 10'h300);
    check_col("offx_c0", 0, 10'h300);
    wait_done("offx_show", n);

    // Vertical wrap: y=250, height 16.
    clear_objs();
    objs[0] = mk(1, 250, 10, 0, 1, 1, 10'h200);
    render(8'd3, "wrap", n);
    check("wrap_count", 32'(obj_count), 32'd1);
    pulse(8'd0);
    check_col("wrap_row9", 10, 10'h10A);
    wait_done("wrap_show", n);
    render(8'd10, "nowrap", n);
    check("nowrap_count", 32'(obj_count), 32'd0);
    pulse(8'd0);
    check_col("nowrap_c10", 10, 10'h300);
    wait_done("nowrap_show", n);

    // Budget overflow with 128 visible 64-wide objects.
    for (int i = 0; i < 128; i++) objs[i] = mk(1, 0, 0, 3, 0, 0, 1);
    render(8'd0, "ovf", n);
    check("ovf_cycles", 32'(n), 32'd1210);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(obj_count), 32'd14);
    pulse(8'd0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    check_col("ovf_c0", 0, 10'h005);
    wait_done("ovf_show", n);

    // line_start mid-DRAW restarts and swaps; reset mid-DRAW aborts.
    pulse(8'd0);
    repeat (300) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    pulse(8'd7);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_count", 32'(obj_count), 32'd0);
    check_col("abort_front_c0", 0, 10'h005);
    check_col("abort_front_c100", 100, 10'h300);
    repeat (250) tick();
    check("rstmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rd_data", 32'(rd_data), 32'h300);
    check("rstmid_count", 32'(obj_count), 32'd0);
    check("rstmid_pix_addr", 32'(pix_addr), 32'd0);
    repeat (5) tick();
    check("rstmid_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
